sequence_generator: RTL



---
 rtl/sequence_generator_if.sv | 29 ++
 rtl/sequence_generator.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sequence_generator_if.sv
// Control and serial-output bundle between a pattern source and its driver.
// The generator sits on the slave side; the block that controls it uses the master side.
interface sequence_generator_if #(
    parameter int LEN    = 4,
    parameter int REPS_W = 4
);
    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;

    logic              start;
    logic              load_pat;
    logic [LEN-1:0]    pattern_in;
    logic [REPS_W-1:0] reps;
    logic              abort;
    logic              out;
    logic              out_valid;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  bit_idx;

    modport master (
        output start, load_pat, pattern_in, reps, abort,
        input  out, out_valid, busy, done, bit_idx
    );

    modport slave (
        input  start, load_pat, pattern_in, reps, abort,
        output out, out_valid, busy, done, bit_idx
    );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a LEN-bit pattern out MSB first, repeated a
// programmable number of times with a fixed idle gap between repetitions.
module sequence_generator #(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int             REPS_W  = 4,
    parameter int             GAP     = 2
) (
    input  logic                clk,
    input  logic                rst,
    sequence_generator_if.slave bus_io
);
    localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEN-1:0]    pattern_q, pattern_d;
    logic [REPS_W-1:0] repsLeft_q, repsLeft_d;
    logic [GW-1:0]     gapCnt_q, gapCnt_d;
    logic [IDX_W-1:0]  bitIdx_q, bitIdx_d;
    logic              out_q, out_d;
    logic              outValid_q, outValid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LEN-1:0]    startPat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pattern_q  <= PATTERN;
            repsLeft_q <= '0;
            gapCnt_q   <= '0;
            bitIdx_q   <= '0;
            out_q      <= 1'b0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            repsLeft_q <= repsLeft_d;
            gapCnt_q   <= gapCnt_d;
            bitIdx_q   <= bitIdx_d;
            out_q      <= out_d;
            outValid_q <= outValid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Outputs are computed one cycle ahead so every output comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        repsLeft_d = repsLeft_q;
        gapCnt_d   = gapCnt_q;
        bitIdx_d   = '0;
        out_d      = 1'b0;
        outValid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        startPat   = bus_io.load_pat ? bus_io.pattern_in : pattern_q;

        case (state_q)
            ST_IDLE: begin
                if (!bus_io.abort) begin
                    if (bus_io.load_pat) begin
                        pattern_d = bus_io.pattern_in;
                    end
                    if (bus_io.start) begin
                        repsLeft_d = (bus_io.reps == '0) ? REPS_W'(1) : bus_io.reps;
                        state_d    = ST_SEND;
                        bitIdx_d   = IDX_LAST;
                        out_d      = startPat[LEN-1];
                        outValid_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (bus_io.abort) begin
                    state_d = ST_IDLE;
                end else if (bitIdx_q != '0) begin
                    bitIdx_d   = bitIdx_q - IDX_W'(1);
                    out_d      = pattern_q[bitIdx_q - IDX_W'(1)];
                    outValid_d = 1'b1;
                    busy_d     = 1'b1;
                end else if (repsLeft_q > REPS_W'(1)) begin
                    repsLeft_d = repsLeft_q - REPS_W'(1);
                    busy_d     = 1'b1;
                    if (GAP > 0) begin
                        state_d  = ST_GAP;
                        gapCnt_d = GAP_LAST;
                    end else begin
                        bitIdx_d   = IDX_LAST;
                        out_d      = pattern_q[LEN-1];
                        outValid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            ST_GAP: begin
                busy_d = 1'b1;
                if (bus_io.abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (gapCnt_q == '0) begin
                    state_d    = ST_SEND;
                    bitIdx_d   = IDX_LAST;
                    out_d      = pattern_q[LEN-1];
                    outValid_d = 1'b1;
                end else begin
                    gapCnt_d = gapCnt_q - GW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_io.out       = out_q;
    assign bus_io.out_valid = outValid_q;
    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.bit_idx   = bitIdx_q;
endmodule
